// File: rtl/sirv_qspi_byte_phy_if.sv
// Byte-operation, configuration and pad bundle between the QSPI frame logic and the byte PHY.
interface sirv_qspi_byte_phy_if #(
    parameter int DIV_W = 12
);
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_cpol;
    logic [1:0]       cfg_proto;

    logic             op_valid;
    logic             op_ready;
    logic [7:0]       op_data;
    logic             op_dir;
    logic [1:0]       op_cs_id;
    logic             op_last;

    logic             rx_valid;
    logic [7:0]       rx_data;

    logic             sck;
    logic [3:0]       cs_n;
    logic [3:0]       dq_o;
    logic [3:0]       dq_oe;
    logic [3:0]       dq_i;

    modport master (
        output cfg_div, cfg_cpol, cfg_proto,
        output op_valid, op_data, op_dir, op_cs_id, op_last,
        input  op_ready, rx_valid, rx_data,
        input  sck, cs_n, dq_o, dq_oe,
        output dq_i
    );

    modport slave (
        input  cfg_div, cfg_cpol, cfg_proto,
        input  op_valid, op_data, op_dir, op_cs_id, op_last,
        output op_ready, rx_valid, rx_data,
        output sck, cs_n, dq_o, dq_oe,
        input  dq_i
    );
endinterface

// File: rtl/sirv_qspi_byte_phy.sv
// QSPI byte engine: shifts one byte per operation in single/dual/quad mode (CPHA=0).
//   state    | meaning
//   IDLE     | waiting for an op; frame may still be open with CS held
//   SETUP    | first half-period of a fresh frame, first bits on dq, sck=cpol
//   SHIFT    | 2N half-periods, leading edge samples, trailing edge shifts
//   HOLD     | one half-period of CS hold after the last byte of a frame
module sirv_qspi_byte_phy #(
    parameter int DIV_W = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    sirv_qspi_byte_phy_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       proto_q, proto_d;
    logic             cpol_q, cpol_d;
    logic             dir_q, dir_d;
    logic             last_q, last_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [3:0]       edges_q, edges_d;
    logic             sck_q, sck_d;
    logic [3:0]       cs_n_q, cs_n_d;
    logic             frame_q, frame_d;
    logic             gap_q, gap_d;

    logic             tick;
    logic [DIV_W-1:0] cnt_adv;
    logic [1:0]       mode_in;
    logic             op_ready;
    logic             leading;
    logic [3:0]       dq_o_c;
    logic [3:0]       dq_oe_c;

    assign tick     = (cnt_q == div_q);
    assign cnt_adv  = tick ? '0 : cnt_q + DIV_W'(1);
    // Reserved protocol code 3 collapses onto single at latch time.
    assign mode_in  = (bus.cfg_proto == 2'd3) ? 2'd0 : bus.cfg_proto;
    // gap_q keeps ready low for one cycle after a byte or a frame close.
    assign op_ready = (state_q == ST_IDLE) && !gap_q;
    assign leading  = (sck_q == cpol_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        proto_d    = proto_q;
        cpol_d     = cpol_q;
        dir_d      = dir_q;
        last_d     = last_q;
        tx_d       = tx_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        edges_d    = edges_q;
        sck_d      = sck_q;
        cs_n_d     = cs_n_q;
        frame_d    = frame_q;
        gap_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!frame_q) begin
                    sck_d = bus.cfg_cpol;
                end
                if (bus.op_valid && op_ready) begin
                    div_d   = bus.cfg_div;
                    proto_d = mode_in;
                    cpol_d  = bus.cfg_cpol;
                    dir_d   = bus.op_dir;
                    last_d  = bus.op_last;
                    tx_d    = bus.op_data;
                    sck_d   = bus.cfg_cpol;
                    case (mode_in)
                        2'd1:    edges_d = 4'd7;
                        2'd2:    edges_d = 4'd3;
                        default: edges_d = 4'd15;
                    endcase
                    if (frame_q) begin
                        state_d = ST_SHIFT;
                    end else begin
                        cs_n_d  = ~(4'b0001 << bus.op_cs_id);
                        frame_d = 1'b1;
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                cnt_d = cnt_adv;
                if (tick) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_adv;
                if (tick) begin
                    sck_d = ~sck_q;
                    if (leading) begin
                        case (proto_q)
                            2'd1:    rx_sh_d = {rx_sh_q[5:0], bus.dq_i[1:0]};
                            2'd2:    rx_sh_d = {rx_sh_q[3:0], bus.dq_i};
                            default: rx_sh_d = {rx_sh_q[6:0], bus.dq_i[1]};
                        endcase
                    end else begin
                        case (proto_q)
                            2'd1:    tx_d = {tx_q[5:0], 2'b00};
                            2'd2:    tx_d = {tx_q[3:0], 4'b0000};
                            default: tx_d = {tx_q[6:0], 1'b0};
                        endcase
                    end
                    if (edges_q == 4'd0) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = rx_sh_q;
                        gap_d      = !last_q;
                        state_d    = last_q ? ST_HOLD : ST_IDLE;
                    end else begin
                        edges_d = edges_q - 4'd1;
                    end
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_adv;
                if (tick) begin
                    cs_n_d  = 4'hF;
                    frame_d = 1'b0;
                    gap_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dq_o_c  = {3'b000, tx_q[7]};
        dq_oe_c = 4'b0000;
        case (proto_q)
            2'd1:    dq_o_c = {2'b00, tx_q[7:6]};
            2'd2:    dq_o_c = tx_q[7:4];
            default: dq_o_c = {3'b000, tx_q[7]};
        endcase
        if (frame_q) begin
            case (proto_q)
                2'd1:    dq_oe_c = {2'b00, {2{dir_q}}};
                2'd2:    dq_oe_c = {4{dir_q}};
                default: dq_oe_c = 4'b0001;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            proto_q    <= 2'd0;
            cpol_q     <= 1'b0;
            dir_q      <= 1'b0;
            last_q     <= 1'b0;
            tx_q       <= 8'h00;
            rx_sh_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            edges_q    <= 4'd0;
            sck_q      <= 1'b0;
            cs_n_q     <= 4'hF;
            frame_q    <= 1'b0;
            gap_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            proto_q    <= proto_d;
            cpol_q     <= cpol_d;
            dir_q      <= dir_d;
            last_q     <= last_d;
            tx_q       <= tx_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            edges_q    <= edges_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            frame_q    <= frame_d;
            gap_q      <= gap_d;
        end
    end

    assign bus.op_ready = op_ready;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.sck      = sck_q;
    assign bus.cs_n     = cs_n_q;
    assign bus.dq_o     = dq_o_c;
    assign bus.dq_oe    = dq_oe_c;
endmodule

// File: tb/tb_sirv_qspi_byte_phy.sv
// Directed bench for the QSPI byte PHY; expected values are hand-derived from the timing rules.
module tb_sirv_qspi_byte_phy;
    logic clk = 1'b0;
    logic rst;
    logic loop_en;
    logic [3:0] dq_pat;
    int checks = 0;
    int failures = 0;

    int lat, tog, mgap;
    logic [7:0]  rxd;
    logic [31:0] seq;
    logic [3:0]  oe0, cs0;
    logic        first_lvl;
    bit          moved, ok;

    always #5 clk = ~clk;

    sirv_qspi_byte_phy_if #(.DIV_W(12)) bus ();

    sirv_qspi_byte_phy #(.DIV_W(12)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Single-mode loopback ties MISO (dq[1]) to MOSI (dq[0]).
    assign bus.dq_i = loop_en ? {2'b00, bus.dq_o[0], 1'b0} : dq_pat;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] d, input logic dir, input logic [1:0] cs,
                        input logic last, output bit accepted);
        int n;
        bus.op_data  = d;
        bus.op_dir   = dir;
        bus.op_cs_id = cs;
        bus.op_last  = last;
        bus.op_valid = 1'b1;
        n = 0;
        while (!bus.op_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        accepted = (n < 100);
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
    endtask

    task automatic wait_rx(input logic cpol, input logic [3:0] pat2,
                           output int l, output logic [7:0] r, output int t,
                           output logic [31:0] s, output int mg, output logic [3:0] oe,
                           output logic [3:0] cs, output bit mv, output logic fl);
        logic prev;
        int last_t;
        prev = bus.sck;
        t = 0; s = 0; mg = 1000; last_t = 0; mv = 0; l = 0; r = 8'hxx;
        oe = 4'hx; cs = 4'hx; fl = 1'bx;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c == 1) begin
                oe = bus.dq_oe;
                cs = bus.cs_n;
            end else if (bus.cs_n !== cs) begin
                mv = 1;
            end
            if (bus.sck !== prev) begin
                t++;
                if (t == 1) fl = bus.sck;
                if (t > 1 && (c - last_t) < mg) mg = c - last_t;
                last_t = c;
                prev = bus.sck;
                if (bus.sck !== cpol) begin
                    s = {s[27:0], bus.dq_o};
                    dq_pat = pat2;
                end
            end
            if (bus.rx_valid) begin
                l = c;
                r = bus.rx_data;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.sck !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", bus.sck); end
        checks++; if (bus.cs_n !== 4'hF) begin failures++; $display("FAIL reset_cs_n got=%h exp=f", bus.cs_n); end
        checks++; if (bus.dq_o !== 4'h0) begin failures++; $display("FAIL reset_dq_o got=%h exp=0", bus.dq_o); end
        checks++; if (bus.dq_oe !== 4'h0) begin failures++; $display("FAIL reset_dq_oe got=%h exp=0", bus.dq_oe); end
        checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", bus.rx_valid); end
        checks++; if (bus.rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", bus.rx_data); end
        checks++; if (bus.op_ready !== 1'b1) begin failures++; $display("FAIL reset_op_ready got=%b exp=1", bus.op_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        bus.cfg_div = 12'd0; bus.cfg_cpol = 1'b0; bus.cfg_proto = 2'd0; loop_en = 1'b1;
        send(8'hA5, 1'b1, 2'd2, 1'b1, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_accept got=%b exp=1", ok); end
        wait_rx(1'b0, 4'h0, lat, rxd, tog, seq, mgap, oe0, cs0, moved, first_lvl);
        checks++; if (cs0 !== 4'b1011) begin failures++; $display("FAIL single_cs_n got=%b exp=1011", cs0); end
        checks++; if (oe0 !== 4'b0001) begin failures++; $display("FAIL single_dq_oe got=%b exp=0001", oe0); end
        checks++; if (tog !== 16) begin failures++; $display("FAIL single_edges got=%0d exp=16", tog); end
        checks++; if (seq !== 32'h10100101) begin failures++; $display("FAIL single_dq_o_seq got=%h exp=10100101", seq); end
        checks++; if (rxd !== 8'hA5) begin failures++; $display("FAIL single_rx_data got=%h exp=a5", rxd); end
        checks++; if (lat !== 18) begin failures++; $display("FAIL single_latency got=%0d exp=18", lat); end
        checks++; if (moved !== 1'b0) begin failures++; $display("FAIL single_cs_stable got=%b exp=0", moved); end
        @(negedge clk);
        checks++; if (bus.cs_n !== 4'hF) begin failures++; $display("FAIL single_cs_release got=%h exp=f", bus.cs_n); end
        checks++; if (bus.op_ready !== 1'b0) begin failures++; $display("FAIL single_ready_gap got=%b exp=0", bus.op_ready); end
        @(negedge clk);
        checks++; if (bus.op_ready !== 1'b1) begin failures++; $display("FAIL single_ready_back got=%b exp=1", bus.op_ready); end
    endtask

    task automatic test_quad_rx();
        bus.cfg_div = 12'd3; bus.cfg_cpol = 1'b0; bus.cfg_proto = 2'd2; loop_en = 1'b0; dq_pat = 4'h3;
        send(8'hFF, 1'b0, 2'd0, 1'b1, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL quad_accept got=%b exp=1", ok); end
        wait_rx(1'b0, 4'hC, lat, rxd, tog, seq, mgap, oe0, cs0, moved, first_lvl);
        checks++; if (oe0 !== 4'b0000) begin failures++; $display("FAIL quad_dq_oe got=%b exp=0000", oe0); end
        checks++; if (rxd !== 8'h3C) begin failures++; $display("FAIL quad_rx_data got=%h exp=3c", rxd); end
        checks++; if (lat !== 21) begin failures++; $display("FAIL quad_latency got=%0d exp=21", lat); end
        checks++; if (tog !== 4) begin failures++; $display("FAIL quad_edges got=%0d exp=4", tog); end
        checks++; if (mgap !== 4) begin failures++; $display("FAIL quad_edge_spacing got=%0d exp=4", mgap); end
        repeat (4) @(negedge clk);
        checks++; if (bus.cs_n !== 4'hF) begin failures++; $display("FAIL quad_cs_release got=%h exp=f", bus.cs_n); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bus.cfg_div = 12'd0; bus.cfg_cpol = 1'b0; bus.cfg_proto = 2'd1; loop_en = 1'b0; dq_pat = 4'b0010;
        send(8'hC6, 1'b1, 2'd1, 1'b0, ok);
        wait_rx(1'b0, 4'b0010, lat, rxd, tog, seq, mgap, oe0, cs0, moved, first_lvl);
        checks++; if (lat !== 10) begin failures++; $display("FAIL dual1_latency got=%0d exp=10", lat); end
        checks++; if (cs0 !== 4'b1101) begin failures++; $display("FAIL dual1_cs_n got=%b exp=1101", cs0); end
        checks++; if (oe0 !== 4'b0011) begin failures++; $display("FAIL dual1_dq_oe got=%b exp=0011", oe0); end
        checks++; if (seq[15:0] !== 16'h3012) begin failures++; $display("FAIL dual1_dq_o_seq got=%h exp=3012", seq[15:0]); end
        checks++; if (rxd !== 8'hAA) begin failures++; $display("FAIL dual1_rx_data got=%h exp=aa", rxd); end
        checks++; if (bus.op_ready !== 1'b0) begin failures++; $display("FAIL dual1_ready_at_rx got=%b exp=0", bus.op_ready); end
        send(8'h5A, 1'b1, 2'd3, 1'b1, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL dual2_accept got=%b exp=1", ok); end
        wait_rx(1'b0, 4'b0010, lat, rxd, tog, seq, mgap, oe0, cs0, moved, first_lvl);
        checks++; if (lat !== 9) begin failures++; $display("FAIL dual2_latency got=%0d exp=9", lat); end
        checks++; if (cs0 !== 4'b1101) begin failures++; $display("FAIL dual2_cs_n got=%b exp=1101", cs0); end
        checks++; if (moved !== 1'b0) begin failures++; $display("FAIL dual2_cs_stable got=%b exp=0", moved); end
        checks++; if (seq[15:0] !== 16'h1122) begin failures++; $display("FAIL dual2_dq_o_seq got=%h exp=1122", seq[15:0]); end
        checks++; if (rxd !== 8'hAA) begin failures++; $display("FAIL dual2_rx_data got=%h exp=aa", rxd); end
        @(negedge clk);
        checks++; if (bus.cs_n !== 4'hF) begin failures++; $display("FAIL dual2_cs_release got=%h exp=f", bus.cs_n); end
        @(negedge clk);
    endtask

    task automatic test_cpol1();
        bus.cfg_div = 12'd1; bus.cfg_cpol = 1'b1; bus.cfg_proto = 2'd0; loop_en = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.sck !== 1'b1) begin failures++; $display("FAIL cpol1_idle_sck got=%b exp=1", bus.sck); end
        send(8'h3C, 1'b1, 2'd0, 1'b1, ok);
        bus.cfg_div = 12'd0;
        wait_rx(1'b1, 4'h0, lat, rxd, tog, seq, mgap, oe0, cs0, moved, first_lvl);
        checks++; if (first_lvl !== 1'b0) begin failures++; $display("FAIL cpol1_first_edge got=%b exp=0", first_lvl); end
        checks++; if (lat !== 35) begin failures++; $display("FAIL cpol1_latency got=%0d exp=35", lat); end
        checks++; if (mgap !== 2) begin failures++; $display("FAIL cpol1_edge_spacing got=%0d exp=2", mgap); end
        checks++; if (tog !== 16) begin failures++; $display("FAIL cpol1_edges got=%0d exp=16", tog); end
        checks++; if (seq !== 32'h00111100) begin failures++; $display("FAIL cpol1_dq_o_seq got=%h exp=00111100", seq); end
        checks++; if (rxd !== 8'h3C) begin failures++; $display("FAIL cpol1_rx_data got=%h exp=3c", rxd); end
        repeat (4) @(negedge clk);
        bus.cfg_cpol = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.sck !== 1'b0) begin failures++; $display("FAIL cpol0_idle_sck got=%b exp=0", bus.sck); end
    endtask

    task automatic test_reset_mid();
        logic prev;
        int t;
        bit saw;
        bus.cfg_div = 12'd0; bus.cfg_cpol = 1'b0; bus.cfg_proto = 2'd0; loop_en = 1'b1;
        send(8'hA5, 1'b1, 2'd0, 1'b1, ok);
        prev = bus.sck;
        t = 0;
        for (int c = 0; c < 100 && t < 5; c++) begin
            @(negedge clk);
            if (bus.sck !== prev) begin
                t++;
                prev = bus.sck;
            end
        end
        checks++; if (t !== 5) begin failures++; $display("FAIL rstmid_reach_edge5 got=%0d exp=5", t); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.cs_n !== 4'hF) begin failures++; $display("FAIL rstmid_cs_n got=%h exp=f", bus.cs_n); end
        checks++; if (bus.dq_oe !== 4'h0) begin failures++; $display("FAIL rstmid_dq_oe got=%h exp=0", bus.dq_oe); end
        checks++; if (bus.sck !== 1'b0) begin failures++; $display("FAIL rstmid_sck got=%b exp=0", bus.sck); end
        checks++; if (bus.rx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_rx_valid got=%b exp=0", bus.rx_valid); end
        rst = 1'b0;
        saw = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rx_valid) saw = 1;
        end
        checks++; if (saw !== 1'b0) begin failures++; $display("FAIL rstmid_no_rx got=%b exp=0", saw); end
        send(8'h5A, 1'b1, 2'd0, 1'b1, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rstmid_accept got=%b exp=1", ok); end
        wait_rx(1'b0, 4'h0, lat, rxd, tog, seq, mgap, oe0, cs0, moved, first_lvl);
        checks++; if (lat !== 18) begin failures++; $display("FAIL rstmid_latency got=%0d exp=18", lat); end
        checks++; if (rxd !== 8'h5A) begin failures++; $display("FAIL rstmid_rx_data got=%h exp=5a", rxd); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_proto3();
        bus.cfg_div = 12'd0; bus.cfg_cpol = 1'b0; bus.cfg_proto = 2'd3; loop_en = 1'b1;
        send(8'h96, 1'b0, 2'd3, 1'b1, ok);
        wait_rx(1'b0, 4'h0, lat, rxd, tog, seq, mgap, oe0, cs0, moved, first_lvl);
        checks++; if (oe0 !== 4'b0001) begin failures++; $display("FAIL proto3_dq_oe got=%b exp=0001", oe0); end
        checks++; if (cs0 !== 4'b0111) begin failures++; $display("FAIL proto3_cs_n got=%b exp=0111", cs0); end
        checks++; if (tog !== 16) begin failures++; $display("FAIL proto3_edges got=%0d exp=16", tog); end
        checks++; if (lat !== 18) begin failures++; $display("FAIL proto3_latency got=%0d exp=18", lat); end
        checks++; if (rxd !== 8'h96) begin failures++; $display("FAIL proto3_rx_data got=%h exp=96", rxd); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        loop_en = 1'b0;
        dq_pat = 4'h0;
        bus.cfg_div = 12'd0;
        bus.cfg_cpol = 1'b0;
        bus.cfg_proto = 2'd0;
        bus.op_valid = 1'b0;
        bus.op_data = 8'h00;
        bus.op_dir = 1'b0;
        bus.op_cs_id = 2'd0;
        bus.op_last = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_quad_rx();
        test_back_to_back();
        test_cpol1();
        test_reset_mid();
        test_proto3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sirv_qspi_byte_phy.md
# sirv_qspi_byte_phy

Byte-level physical engine for the QSPI controller. It accepts one byte operation at a time from the controller's frame logic, drives chip select, the serial clock and the DQ lines in single, dual or quad protocol, and returns the captured byte. It sits directly between the controller's TileLink-facing register and FIFO logic and the `io_port_*` pad signals.

## Interface
- `DIV_W`, default 12: width of the clock divider field.
- `clock` input 1: the only clock.
- `reset` input 1: synchronous, active-high.
- `cfg_div` input DIV_W: SCK half-period is `cfg_div+1` clocks.
- `cfg_cpol` input 1: SCK idle level. CPHA is fixed at 0.
- `cfg_proto` input 2: 0 single, 1 dual, 2 quad, 3 reserved (treated as single).
- `op_valid` input 1: a byte operation is offered.
- `op_ready` output 1: the operation is accepted when `op_valid && op_ready`.
- `op_data` input 8: byte to transmit, MSB first.
- `op_dir` input 1: 1 = transmit, 0 = receive. Only meaningful in dual and quad.
- `op_cs_id` input 2: chip select index, used only by the first op of a frame.
- `op_last` input 1: deassert CS after this byte.
- `rx_valid` output 1: one-cycle pulse when a byte completes.
- `rx_data` output 8: captured byte, valid with `rx_valid`.
- `sck` output 1: serial clock.
- `cs_n` output 4: active-low chip selects.
- `dq_o` output 4: DQ output data.
- `dq_oe` output 4: DQ output enables.
- `dq_i` input 4: DQ input data.

## Operation
- FSM states: IDLE, SETUP, SHIFT, HOLD.
- Divider counter `cnt` counts 0..`cfg_div`. A tick fires when `cnt==cfg_div`, then `cnt` returns to 0. `cnt` is held at 0 in IDLE.
- **IDLE**
  - `op_ready=1`.
  - On accept, latch `cfg_div`, `cfg_proto`, `cfg_cpol`, `op_dir`, `op_data` and `op_last`. Later config changes have no effect until the next accept.
  - Bits per edge B is 1, 2 or 4, so the byte takes N = 8/B bit-slots.
- **Frame start**
  - If no frame is open: latch `op_cs_id`, drive `cs_n[cs_id]=0` next cycle, and go to SETUP.
  - If a frame is open: ignore `op_cs_id` and go straight to SHIFT.
- **SETUP**
  - Lasts one half-period.
  - The first output bits are driven and `sck`=cpol.
  - Go to SHIFT on the tick.
- **SHIFT**
  - Lasts 2N half-periods. `sck` toggles on every tick.
  - Leading edge (away from cpol): sample input lines into the rx shift register, MSB first.
    - Single: sample `dq_i[1]`.
    - Dual: sample `dq_i[1:0]`.
    - Quad: sample `dq_i[3:0]`.
  - Trailing edge: shift the next B tx bits onto `dq_o`.
  - After the final trailing edge:
    - Pulse `rx_valid` and present `rx_data`.
    - If `op_last`: go to HOLD.
    - Otherwise: go to IDLE with CS held.
- **HOLD**
  - Lasts one half-period with CS still asserted.
  - Then set `cs_n=4'hF` and go to IDLE with the frame closed.
- **dq_oe** while a frame is open:
  - Single: `4'b0001`.
  - Dual: `4'b0011` when `op_dir=1`, `4'b0000` when `op_dir=0`.
  - Quad: `4'b1111` when `op_dir=1`, `4'b0000` when `op_dir=0`.
  - In IDLE with no frame open: `4'b0000`.
- **rx_data** is always the sampled value, including on transmit bytes.
- **sck** while idle: with no frame open, `sck` follows `cfg_cpol`, registered, every cycle.

## Timing
- Reset values:
  - `sck=0`, `cs_n=4'hF`, `dq_o=0`, `dq_oe=0`, `rx_valid=0`, `rx_data=0`, `op_ready=1`.
  - State IDLE, no frame open.
- Reset takes priority over everything. Asserting it mid-byte aborts the byte:
  - No `rx_valid`.
  - All outputs return to reset values on the next cycle.
- `op_ready` is low from the cycle after acceptance until the cycle after `rx_valid` (continuing frame) or the end of HOLD (`op_last`).
- Latency from the accept cycle to `rx_valid`, with H = `cfg_div+1`:
  - Fresh frame: H·(1+2N)+1 cycles.
  - Continuing frame: H·2N+1 cycles.
- Example: single, `cfg_div=0` gives 18 cycles for a fresh frame and 17 for a continuing one.
- Back-to-back ops in the same frame:
  - A new op may be accepted in the cycle after `rx_valid`.
  - `sck` stays at cpol for at least one cycle between bytes.
- `cs_n` deasserts H cycles after the `rx_valid` of an `op_last` byte. The earliest next frame asserts CS 2 cycles after that.

## Test plan
- **Single, fresh frame, `op_last=1`.** `cfg_div=0`, cpol=0, `op_data=8'hA5`, `cs_id=2`, `dq_i[1]` looped from `dq_o[0]`.
  - `cs_n=4'b1011`.
  - 8 rising edges; `dq_o[0]` sequence 1,0,1,0,0,1,0,1.
  - `rx_data=8'hA5` at cycle 18.
  - `cs_n=4'hF` one cycle later.
- **Quad receive.** `cfg_div=3`, `op_dir=0`, `dq_i` = 4'h3 then 4'hC on successive leading edges.
  - `dq_oe=0`.
  - `rx_data=8'h3C`; latency 4·5+1=21.
- **Two-byte dual frame.** First op `op_last=0`, `cs_id=1`; second op `cs_id=3`, `op_last=1`.
  - `cs_n=4'b1101` held continuously across both bytes.
  - The second byte has no SETUP phase.
  - Two `rx_valid` pulses.
- **cpol=1.** `sck` idles high; the first edge in SHIFT is falling. Changing `cfg_div` mid-byte does not change the edge spacing.
- **Reset mid-byte.** Assert `reset` at the 5th `sck` edge.
  - Next cycle `cs_n=4'hF`, `dq_oe=0`, `sck=0`, no `rx_valid`.
  - A new op is accepted immediately after reset releases.
- **Reserved `cfg_proto=3`.** Behaves identically to single: 8 bit-slots and `dq_oe=4'b0001`.
